// File: rtl/branch_resolve_ctrl_if.sv
// rtl/branch_resolve_ctrl_if.sv - branch request/resolution bundle between ID, hazard unit and PC logic
interface branch_resolve_ctrl_if #(
  parameter int CNT_W  = 32,
  parameter int WAIT_W = 4
);
  logic              br_valid;
  logic [2:0]        cmp_op;
  logic [31:0]       rs_val;
  logic [31:0]       rt_val;
  logic              rs_ready;
  logic              rt_ready;
  logic [31:0]       pc_id;
  logic [15:0]       imm16;
  logic              flush;
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  br_total;
  logic [CNT_W-1:0]  br_taken;
  logic              bad_op;

  modport master (
    output br_valid, cmp_op, rs_val, rt_val, rs_ready, rt_ready, pc_id, imm16, flush,
    input  stall, redirect, redirect_pc, wait_cnt, br_total, br_taken, bad_op
  );

  modport slave (
    input  br_valid, cmp_op, rs_val, rt_val, rs_ready, rt_ready, pc_id, imm16, flush,
    output stall, redirect, redirect_pc, wait_cnt, br_total, br_taken, bad_op
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - ID-stage conditional branch sequencer with operand wait and statistics
module branch_resolve_ctrl #(
  parameter int CNT_W  = 32,
  parameter int WAIT_W = 4
) (
  input logic                  clk,
  input logic                  reset,
  branch_resolve_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic              ready;
  logic              capture;
  logic              resolve_en;
  logic              wait_load;
  logic              wait_inc;
  logic              wait_clr;
  logic              stall;

  logic              rs_neg;
  logic              rs_zero;
  logic              taken_d;
  logic              bad_d;
  logic [31:0]       target_d;

  logic              taken_q;
  logic              bad_q;
  logic [31:0]       redirect_pc_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0]  br_total_q;
  logic [CNT_W-1:0]  br_taken_q;
  logic              bad_op_q;

  // Only beq/bne compare against rt; the unary forms need rs alone.
  always_comb begin
    ready = bus.rs_ready & ((bus.cmp_op[2:1] != 2'b00) | bus.rt_ready);
  end

  always_comb begin
    rs_neg  = bus.rs_val[31];
    rs_zero = (bus.rs_val == 32'd0);
    taken_d = 1'b0;
    bad_d   = 1'b0;
    case (bus.cmp_op)
      3'b000:  taken_d = (bus.rs_val == bus.rt_val);
      3'b001:  taken_d = (bus.rs_val != bus.rt_val);
      3'b010:  taken_d = rs_neg;
      3'b011:  taken_d = rs_neg | rs_zero;
      3'b100:  taken_d = ~rs_neg & ~rs_zero;
      3'b101:  taken_d = ~rs_neg;
      default: bad_d   = 1'b1;
    endcase
    target_d = bus.pc_id + 32'd4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  end

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    capture    = 1'b0;
    resolve_en = 1'b0;
    wait_load  = 1'b0;
    wait_inc   = 1'b0;
    wait_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = bus.br_valid;
        if (bus.br_valid) begin
          if (ready) begin
            capture  = 1'b1;
            wait_clr = 1'b1;
            state_d  = RESOLVE;
          end else begin
            wait_load = 1'b1;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (ready) begin
          capture = 1'b1;
          state_d = RESOLVE;
        end else begin
          wait_inc = 1'b1;
        end
      end
      RESOLVE: begin
        // br_valid still names the branch just resolved, so it is not re-examined here
        resolve_en = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d    = IDLE;
      stall      = 1'b0;
      capture    = 1'b0;
      resolve_en = 1'b0;
      wait_load  = 1'b0;
      wait_inc   = 1'b0;
      wait_clr   = 1'b1;
    end
    if (reset) begin
      stall = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      taken_q       <= 1'b0;
      bad_q         <= 1'b0;
      redirect_pc_q <= 32'd0;
      wait_cnt_q    <= '0;
      br_total_q    <= '0;
      br_taken_q    <= '0;
      bad_op_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        taken_q       <= taken_d;
        bad_q         <= bad_d;
        redirect_pc_q <= target_d;
      end
      if (wait_clr) begin
        wait_cnt_q <= '0;
      end else if (wait_load) begin
        wait_cnt_q <= WAIT_W'(1);
      end else if (wait_inc && (wait_cnt_q != '1)) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end
      if (resolve_en) begin
        br_total_q <= br_total_q + CNT_W'(1);
        br_taken_q <= br_taken_q + CNT_W'(taken_q);
        if (bad_q) begin
          bad_op_q <= 1'b1;
        end
      end
    end
  end

  assign bus.stall       = stall;
  assign bus.redirect    = resolve_en & taken_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.wait_cnt    = wait_cnt_q;
  assign bus.br_total    = br_total_q;
  assign bus.br_taken    = br_taken_q;
  assign bus.bad_op      = bad_op_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - vector, directed and randomized checks of branch_resolve_ctrl
module tb_branch_resolve_ctrl;

  localparam int CNT_W   = 4;
  localparam int WAIT_W  = 4;
  localparam int WAITMAX = (1 << WAIT_W) - 1;
  localparam int CNTMOD  = 1 << CNT_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.CNT_W(CNT_W), .WAIT_W(WAIT_W)) bus ();
  branch_resolve_ctrl #(.CNT_W(CNT_W), .WAIT_W(WAIT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level reference: a branch is either waiting for operands or has a
  // captured outcome that is published on the following cycle.
  bit          m_wait, m_res, m_tk, m_bad, m_bad_op;
  logic [31:0] m_pc;
  int          m_wcnt, m_tot, m_tkn;

  function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    int s;
    s = $signed(rs);
    case (op)
      3'd0:    return rs == rt;
      3'd1:    return rs != rt;
      3'd2:    return s < 0;
      3'd3:    return s <= 0;
      3'd4:    return s > 0;
      3'd5:    return s >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [15:0] imm);
    int off;
    off = int'($signed(imm)) * 4;
    return pc + 32'd4 + 32'(off);
  endfunction

  function automatic bit ref_ready(input logic [2:0] op, input bit rsr, input bit rtr);
    return rsr && ((op == 3'd0 || op == 3'd1) ? rtr : 1'b1);
  endfunction

  task automatic model_reset();
    m_wait = 0; m_res = 0; m_tk = 0; m_bad = 0; m_bad_op = 0;
    m_pc = 32'd0; m_wcnt = 0; m_tot = 0; m_tkn = 0;
  endtask

  task automatic model_update();
    bit rdy;
    rdy = ref_ready(bus.cmp_op, bus.rs_ready, bus.rt_ready);
    if (bus.flush) begin
      m_wait = 0; m_res = 0; m_wcnt = 0;
    end else if (m_res) begin
      m_tot++;
      m_tkn += int'(m_tk);
      if (m_bad) m_bad_op = 1;
      m_res = 0;
    end else if (m_wait || bus.br_valid) begin
      if (rdy) begin
        if (!m_wait) m_wcnt = 0;
        m_pc   = ref_target(bus.pc_id, bus.imm16);
        m_tk   = ref_taken(bus.cmp_op, bus.rs_val, bus.rt_val);
        m_bad  = bus.cmp_op > 3'd5;
        m_res  = 1;
        m_wait = 0;
      end else begin
        m_wcnt = m_wait ? ((m_wcnt < WAITMAX) ? m_wcnt + 1 : WAITMAX) : 1;
        m_wait = 1;
      end
    end
  endtask

  task automatic check_model();
    bit exp_stall;
    exp_stall = bus.flush ? 1'b0 : m_wait ? 1'b1 : m_res ? 1'b0 : bus.br_valid;
    chk("stall", 32'(bus.stall), 32'(exp_stall));
    chk("redirect", 32'(bus.redirect), 32'(m_res && m_tk && !bus.flush));
    chk("redirect_pc", bus.redirect_pc, m_pc);
    chk("wait_cnt", 32'(bus.wait_cnt), 32'(m_wcnt));
    chk("br_total", 32'(bus.br_total), 32'(m_tot % CNTMOD));
    chk("br_taken", 32'(bus.br_taken), 32'(m_tkn % CNTMOD));
    chk("bad_op", 32'(bus.bad_op), 32'(m_bad_op));
  endtask

  task automatic tick_now();
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    #3;
    tick_now();
  endtask

  task automatic set_br(input bit v, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] pc, input logic [15:0] imm, input bit rsr, input bit rtr);
    bus.br_valid = v; bus.cmp_op = op; bus.rs_val = rs; bus.rt_val = rt;
    bus.pc_id = pc; bus.imm16 = imm; bus.rs_ready = rsr; bus.rt_ready = rtr;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.br_valid = 1'b0;
    bus.flush = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom % 6)
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'd5;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pc;
    logic [15:0] imm;
    bit          rtr;
    bit          exp_tk;
    logic [31:0] exp_tg;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    vecs[0] = '{3'd0, 32'd5,          32'd5, 32'h0000_3000, 16'h0004, 1'b1, 1'b1, 32'h0000_3014};
    vecs[1] = '{3'd1, 32'd7,          32'd7, 32'h0000_3000, 16'h0004, 1'b1, 1'b0, 32'h0000_3014};
    vecs[2] = '{3'd3, 32'd0,          32'd9, 32'h0000_4000, 16'h0010, 1'b0, 1'b1, 32'h0000_4044};
    vecs[3] = '{3'd2, 32'h8000_0000,  32'd0, 32'h0000_0100, 16'hFFFE, 1'b0, 1'b1, 32'h0000_00FC};
    vecs[4] = '{3'd5, 32'h8000_0000,  32'd0, 32'h0000_0200, 16'h0001, 1'b0, 1'b0, 32'h0000_0208};
    vecs[5] = '{3'd4, 32'd0,          32'd0, 32'h0000_0000, 16'h0000, 1'b0, 1'b0, 32'h0000_0004};
    vecs[6] = '{3'd5, 32'd0,          32'd3, 32'hFFFF_FFF0, 16'h0008, 1'b0, 1'b1, 32'h0000_0014};
    vecs[7] = '{3'd1, 32'd1,          32'd2, 32'h0000_1000, 16'h8000, 1'b1, 1'b1, 32'hFFFE_1004};

    // Reset with a branch presented: everything, including stall, must read 0.
    reset = 1'b1;
    bus.flush = 1'b0;
    set_br(1'b1, 3'd0, 32'd1, 32'd1, 32'h1000, 16'd1, 1'b1, 1'b1);
    model_reset();
    #3;
    chk("reset_stall", 32'(bus.stall), 32'd0);
    chk("reset_redirect", 32'(bus.redirect), 32'd0);
    chk("reset_redirect_pc", bus.redirect_pc, 32'd0);
    chk("reset_wait_cnt", 32'(bus.wait_cnt), 32'd0);
    chk("reset_br_total", 32'(bus.br_total), 32'd0);
    chk("reset_bad_op", 32'(bus.bad_op), 32'd0);
    bus.br_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single-cycle branches from the vector table.
    for (int i = 0; i < 8; i++) begin
      set_br(1'b1, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].pc, vecs[i].imm, 1'b1, vecs[i].rtr);
      #3;
      chk("tbl_accept_stall", 32'(bus.stall), 32'd1);
      tick_now();
      #3;
      chk("tbl_resolve_stall", 32'(bus.stall), 32'd0);
      chk("tbl_redirect", 32'(bus.redirect), 32'(vecs[i].exp_tk));
      chk("tbl_target", bus.redirect_pc, vecs[i].exp_tg);
      tick_now();
      bus.br_valid = 1'b0;
      tick();
    end

    // bgtz waiting three cycles on rs.
    sc = 0;
    set_br(1'b1, 3'd4, 32'd1, 32'd0, 32'h0000_3010, 16'hFFFF, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #3;
      if (bus.stall) sc++;
      tick_now();
    end
    bus.rs_ready = 1'b1;
    #3;
    if (bus.stall) sc++;
    chk("bgtz_wait_cnt", 32'(bus.wait_cnt), 32'd3);
    tick_now();
    #3;
    chk("bgtz_stall_cycles", 32'(sc), 32'd4);
    chk("bgtz_redirect", 32'(bus.redirect), 32'd1);
    chk("bgtz_target", bus.redirect_pc, 32'h0000_3010);
    tick_now();
    bus.br_valid = 1'b0;
    tick();

    // beq must wait on rt.
    set_br(1'b1, 3'd0, 32'd9, 32'd9, 32'h0000_0500, 16'h0002, 1'b1, 1'b0);
    tick();
    #3;
    chk("beq_rt_wait_stall", 32'(bus.stall), 32'd1);
    chk("beq_rt_wait_cnt", 32'(bus.wait_cnt), 32'd1);
    tick_now();
    bus.rt_ready = 1'b1;
    tick();
    bus.br_valid = 1'b0;
    tick();
    tick();

    // Flush while waiting.
    set_br(1'b1, 3'd4, 32'd5, 32'd0, 32'h0000_0600, 16'h0003, 1'b0, 1'b0);
    tick();
    tick();
    bus.flush = 1'b1;
    #3;
    chk("flush_stall", 32'(bus.stall), 32'd0);
    chk("flush_redirect", 32'(bus.redirect), 32'd0);
    tick_now();
    bus.flush = 1'b0;
    bus.br_valid = 1'b0;
    #3;
    chk("flush_wait_cnt", 32'(bus.wait_cnt), 32'd0);
    tick_now();

    // Asynchronous reset in the middle of a wait.
    set_br(1'b1, 3'd4, 32'd5, 32'd0, 32'h0000_0700, 16'h0003, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("midreset_stall", 32'(bus.stall), 32'd0);
    chk("midreset_redirect_pc", bus.redirect_pc, 32'd0);
    chk("midreset_wait_cnt", 32'(bus.wait_cnt), 32'd0);
    chk("midreset_br_total", 32'(bus.br_total), 32'd0);
    chk("midreset_br_taken", 32'(bus.br_taken), 32'd0);
    do_reset();

    // 2^CNT_W taken branches bring both counters back to zero.
    for (int k = 0; k < CNTMOD; k++) begin
      set_br(1'b1, 3'd0, 32'd1, 32'd1, 32'h0000_2000, 16'h0001, 1'b1, 1'b1);
      tick();
      bus.br_valid = 1'b0;
      tick();
    end
    #3;
    chk("wrap_br_total", 32'(bus.br_total), 32'd0);
    chk("wrap_br_taken", 32'(bus.br_taken), 32'd0);
    tick_now();

    // Wait counter saturation.
    set_br(1'b1, 3'd5, 32'd0, 32'd0, 32'h0000_0800, 16'h0000, 1'b0, 1'b0);
    repeat (20) tick();
    #3;
    chk("sat_wait_cnt", 32'(bus.wait_cnt), 32'(WAITMAX));
    tick_now();
    bus.rs_ready = 1'b1;
    tick();
    bus.br_valid = 1'b0;
    tick();

    // Reserved condition code.
    set_br(1'b1, 3'd6, 32'd0, 32'd0, 32'h0000_0900, 16'h0001, 1'b1, 1'b1);
    tick();
    bus.br_valid = 1'b0;
    #3;
    chk("reserved_redirect", 32'(bus.redirect), 32'd0);
    tick_now();
    #3;
    chk("reserved_bad_op", 32'(bus.bad_op), 32'd1);
    tick_now();

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      if (!m_wait && !m_res) begin
        set_br(($urandom % 3) != 0, 3'($urandom_range(0, 7)), pick_val(), pick_val(),
               $urandom & 32'hFFFF_FFFC, 16'($urandom), 1'b0, 1'b0);
      end
      bus.rs_ready = ($urandom % 10) < 7;
      bus.rt_ready = ($urandom % 10) < 7;
      bus.flush    = ($urandom % 20) == 0;
      tick();
    end
    bus.flush = 1'b0;
    bus.br_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
ID-stage branch sequencer for the pipelined MIPS core. It holds a conditional branch in ID until its forwarded operands are valid, then evaluates the branch condition on a registered snapshot. It drives PC redirect and IF/ID stall, and keeps branch statistics counters. It sits between the hazard unit, which supplies the operand-ready flags, and the PC/NPC logic.

Parameters:
CNT_W, 32, width of the statistics counters br_total and br_taken
WAIT_W, 4, width of the saturating operand-wait counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
br_valid  in  1  ID holds a conditional branch; held stable while stall=1
cmp_op  in  3  condition select: 000 beq, 001 bne, 010 bltz, 011 blez, 100 bgtz, 101 bgez, 110/111 reserved
rs_val  in  32  forwarded rs value
rt_val  in  32  forwarded rt value
rs_ready  in  1  rs_val is final (no pending producer)
rt_ready  in  1  rt_val is final
pc_id  in  32  PC of the branch in ID
imm16  in  16  branch offset
flush  in  1  synchronous abort of the branch in flight
stall  out  1  freeze PC and IF/ID (combinational)
redirect  out  1  one-cycle pulse: load redirect_pc into PC
redirect_pc  out  32  branch target
wait_cnt  out  WAIT_W  cycles the current/last branch waited for operands, saturating
br_total  out  CNT_W  resolved branches
br_taken  out  CNT_W  resolved taken branches
bad_op  out  1  sticky: a reserved cmp_op was resolved

Behaviour:
- Reset (async, active-high): state=IDLE; redirect=0; redirect_pc=0; wait_cnt=0; br_total=0; br_taken=0; bad_op=0. The stall output is 0 while reset is asserted.
- Operands are ready when rs_ready=1 and, for cmp_op 000/001 only, rt_ready=1. The unary ops 010–101 ignore rt.
- States:
  - IDLE:
    - stall = br_valid.
    - br_valid & ready → RESOLVE, and capture the snapshot.
    - br_valid & !ready → WAIT, and set wait_cnt=1.
    - Otherwise stay in IDLE.
  - WAIT:
    - stall=1.
    - wait_cnt increments each cycle and saturates at all-ones.
    - ready → RESOLVE and capture the snapshot.
  - RESOLVE:
    - stall=0.
    - redirect = taken (registered); redirect_pc = captured target.
    - br_total += 1; br_taken += taken. Both counters wrap modulo 2^CNT_W.
    - br_valid is ignored (it still refers to the same branch). Next state is IDLE unconditionally.
- Snapshot is taken on the capturing clock edge:
  - taken is computed from rs_val/rt_val per cmp_op:
    - beq: rs==rt
    - bne: rs!=rt
    - bltz: rs[31]
    - blez: rs[31] | rs==0
    - bgtz: !rs[31] & rs!=0
    - bgez: !rs[31]
    - 110/111: taken=0 and bad_op is set at RESOLVE.
  - target = pc_id + 4 + (sign_extend(imm16) << 2), modulo 2^32.
- Latency: minimum 1 bubble per branch (stall in the acceptance cycle). The redirect pulse coincides with the delay slot moving into ID, so the delay slot always executes.
- redirect is high only in RESOLVE with taken=1. redirect_pc holds its value until the next capture.
- flush=1 in any state → next state IDLE, no redirect, counters unchanged, wait_cnt cleared. While flush=1, stall=0 in that cycle. flush has priority over every transition.
- wait_cnt resets to 0 only at reset, on flush, or on a new IDLE acceptance with ready=1.

Test Plan:
- beq with rs=rt=5, both ready, pc_id=0x3000, imm16=0x0004 → stall=1 for 1 cycle; next cycle redirect=1, redirect_pc=0x3014; br_total=1, br_taken=1.
- bne with rs=rt=7 → no redirect pulse; br_total increments; br_taken unchanged; redirect_pc=target.
- bgtz with rs_ready low for 3 cycles, rs=0x00000001, imm16=0xFFFF, pc_id=0x3010 → stall=1 for 4 cycles; wait_cnt=3; then redirect=1 with redirect_pc=0x3010.
- blez with rs=0 → taken. bltz with rs=0x80000000 → taken. bgez with rs=0x80000000 → not taken. beq with rt_ready=0 waits, while bgez with rt_ready=0 does not wait.
- flush asserted in WAIT → stall drops that cycle, no redirect, counters unchanged; reset asserted mid-WAIT → all outputs 0 immediately.
- Saturation, wrap and reserved op: with WAIT_W=4, hold rs_ready low for 20 cycles → wait_cnt=15. cmp_op=110 → no redirect and bad_op=1. Preload via 2^CNT_W branches with CNT_W=4 → br_total wraps to 0.
